ipu_int_scheduler: RTL
======================

IPU_INT_SCHEDULER -- requirements
Module: ipu_int_scheduler

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: PCLK input 1 (APB clock, 50 MHz), PRESETn input 1 (async, active-low).
REQ-002 SHALL provide PSEL input 1 (APB select).
REQ-003 SHALL provide PENABLE input 1 (APB access phase).
REQ-004 SHALL provide PWRITE input 1 (1 = write, 0 = read).
REQ-005 SHALL provide PADDR input 16 (byte address; bits [4:2] decoded).
REQ-006 SHALL provide PWDATA input 32 (write data).
REQ-007 SHALL provide PRDATA output 32 (registered read data).
REQ-008 SHALL provide MCU2IPU_CoreOnline input 4 (per-core online, already synchronous to PCLK).
REQ-009 SHALL provide MCU2IPU_NMI input 1, MCU2IPU_FaultInt input 1, MCU2IPU_IntValid input 1, and MCU2IPU_IntInfo input 4, all synchronous to PCLK.
REQ-010 SHALL provide IPU_IRQ output 1 (event-available interrupt).
REQ-011 SHALL have parameter FIFO_DEPTH, default 4 (event queue depth, power of two).

Function
REQ-012 SHALL detect four sources with priority fixed at 0 (highest) to 3:
- src0: NMI rising edge
- src1: FaultInt rising edge
- src2: each cycle IntValid=1, with info = IntInfo
- src3: any CoreOnline bit 1->0, with info = bits that fell
REQ-013 SHALL latch each detected event into a per-source pending bit and info register only while CTRL.EN=1; detections with EN=0 are discarded.
REQ-014 SHALL apply MASK[3:1] to src1..src3 at detection (masked = discarded); src0 is unmaskable.
REQ-015 Each cycle, if any pending bit is set and a FIFO slot is available, SHALL grant the lowest-numbered pending source, push {src[1:0], info[3:0], ts[15:0]}, and clear that pending bit in the same edge.
- A slot is available when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
REQ-016 ts SHALL be a 16-bit free-running counter that wraps 0xFFFF -> 0x0000.
REQ-017 A new detection on a source whose pending bit is already set and not granted this cycle SHALL set sticky OVF and overwrite the info; a detection in the grant cycle re-sets pending with no OVF.
REQ-018 Registers, all zero-wait:
- 0x00 CTRL: [0] EN, RW
- 0x04 MASK: [3:1], RW; [0] reads 0
- 0x08 STATUS: [2:0] count, [3] full, [4] empty, [11:8] pending, [16] OVF, RO
- 0x0C EVENT: [1:0] src, [7:4] info, [31:16] ts, read pops
- 0x10 OVFCLR: writing 1 to bit 0 clears OVF, WO
REQ-019 PRDATA SHALL be loaded at the setup-phase edge (PSEL=1, PENABLE=0, PWRITE=0) and held otherwise; unmapped addresses read 0.
REQ-020 An EVENT read SHALL pop exactly once, on the access-phase edge; an EVENT read while empty returns 0 and does not pop.
REQ-021 Writes SHALL take effect on the access-phase edge. Simultaneous OVFCLR and a new overflow leaves OVF=1.
REQ-022 IPU_IRQ SHALL be registered and equal (count != 0) & EN, so it lags a push by one cycle.
REQ-023 Clearing EN SHALL neither flush the FIFO nor clear pending bits; granting continues.

Reset
REQ-024 On PRESETn=0, asynchronously: PRDATA=0, IPU_IRQ=0, CTRL=0, MASK=0, pending=0, OVF=0, ts=0, FIFO empty, and edge-detect history registers = current-inactive values (NMI/Fault 0, CoreOnline 0xF).
REQ-025 Reset asserted mid-transfer SHALL abort the transfer with no pop and no write.

Structure
REQ-026 Package ipu_int_pkg SHALL hold register offsets, source codes, the event record width (22), and the FIFO_DEPTH default.
REQ-027 SHALL instantiate one sub-module, ipu_int_fifo: synchronous FIFO with push/pop/count/full/empty and same-cycle push+pop when full.

Verification
REQ-028 EN=1, NMI and FaultInt rise in the same cycle -> EVENT reads src=0, then src=1; IPU_IRQ=1 one cycle after the first push.
REQ-029 Five IntValid pulses with info 1..5, no reads -> count=4, full=1, pending[2]=1 with info 5, OVF=0; one EVENT read -> info 1 is returned and info 5 is pushed in the pop cycle.
REQ-030 With the FIFO full and pending[2] set, another IntValid -> OVF=1; OVFCLR write -> OVF=0.
REQ-031 MASK=0xE, then FaultInt, IntValid, and CoreOnline 0xF->0x5 -> only NMI is queued.
REQ-032 CoreOnline 0xF->0xA with ts near 0xFFFF -> event src=3, info=0x5, correct wrapped ts.
REQ-033 EVENT read while empty -> PRDATA=0, count stays 0; PRESETn pulse mid-access -> all outputs 0.

Source files
------------

// File: rtl/ipu_int_pkg.sv
// Shared constants and the event record for the IPU interrupt scheduler.
// Register offsets are byte addresses; only bits [4:2] are decoded.
package ipu_int_pkg;

    localparam int FIFO_DEPTH_DEF = 4;
    localparam int EVT_W          = 22;

    localparam logic [15:0] OFS_CTRL   = 16'h0000;
    localparam logic [15:0] OFS_MASK   = 16'h0004;
    localparam logic [15:0] OFS_STATUS = 16'h0008;
    localparam logic [15:0] OFS_EVENT  = 16'h000C;
    localparam logic [15:0] OFS_OVFCLR = 16'h0010;

    localparam logic [1:0] SRC_NMI   = 2'd0;
    localparam logic [1:0] SRC_FAULT = 2'd1;
    localparam logic [1:0] SRC_INT   = 2'd2;
    localparam logic [1:0] SRC_CORE  = 2'd3;

    typedef struct packed {
        logic [1:0]  src;
        logic [3:0]  info;
        logic [15:0] ts;
    } evt_t;

endpackage

// File: rtl/ipu_int_scheduler_if.sv
// APB slave bus of the interrupt scheduler, bundled for module ports.
// PRDATA is the only slave-driven signal.
interface ipu_int_scheduler_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;

    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA);
    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA);
endinterface

// File: rtl/ipu_int_fifo.sv
// Event queue: synchronous FIFO with combinational head.
// Latency 1 cycle push-to-visible; push is accepted when full only with a same-cycle pop.
module ipu_int_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 22,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_dat,
    input  logic          i_pop,
    output logic [W-1:0]  o_head_dat,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_cnt;
    logic          w_do_push, w_do_pop;

    assign o_full     = (r_cnt == CW'(DEPTH));
    assign o_empty    = (r_cnt == '0);
    assign w_do_pop   = i_pop & ~o_empty;
    assign w_do_push  = i_push & (~o_full | w_do_pop);
    assign o_head_dat = r_mem[r_rptr];
    assign o_count    = r_cnt;

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/ipu_int_scheduler.sv
// Four-source interrupt scheduler: edge/level detect, fixed-priority grant into an event FIFO, APB access.
// Grant 1 cycle after detection, IRQ 1 cycle after push; sources stay pending while the FIFO is full.
module ipu_int_scheduler
    import ipu_int_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    ipu_int_scheduler_if.slave apb,
    input  logic [3:0]         MCU2IPU_CoreOnline,
    input  logic               MCU2IPU_NMI,
    input  logic               MCU2IPU_FaultInt,
    input  logic               MCU2IPU_IntValid,
    input  logic [3:0]         MCU2IPU_IntInfo,
    output logic               IPU_IRQ
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [2:0] IDX_CTRL   = OFS_CTRL[4:2];
    localparam logic [2:0] IDX_MASK   = OFS_MASK[4:2];
    localparam logic [2:0] IDX_STATUS = OFS_STATUS[4:2];
    localparam logic [2:0] IDX_EVENT  = OFS_EVENT[4:2];
    localparam logic [2:0] IDX_OVFCLR = OFS_OVFCLR[4:2];

    logic            r_en, r_ovf, r_irq, r_pop_ok, r_nmi_d, r_flt_d;
    logic [3:1]      r_mask;
    logic [3:0]      r_pend, r_core_d;
    logic [3:0][3:0] r_info;
    logic [15:0]     r_ts;
    logic [31:0]     r_prdata;

    logic            w_setup, w_access, w_wr, w_pop, w_push, w_new_ovf, w_full, w_empty;
    logic [2:0]      w_idx;
    logic [3:0]      w_fell, w_det, w_gnt;
    logic [3:0][3:0] w_new_info;
    logic [1:0]      w_gnt_src;
    logic [CW-1:0]   w_cnt;
    logic [31:0]     w_rdata;
    evt_t            w_push_evt, w_head;
    logic            w_unused;

    assign w_setup  = apb.PSEL & ~apb.PENABLE;
    assign w_access = apb.PSEL & apb.PENABLE;
    assign w_idx    = apb.PADDR[4:2];
    assign w_wr     = w_access & apb.PWRITE;
    // r_pop_ok remembers that the setup phase returned a real event, so an empty read never pops.
    assign w_pop    = w_access & ~apb.PWRITE & (w_idx == IDX_EVENT) & r_pop_ok;
    assign w_unused = ^{apb.PADDR[15:5], apb.PADDR[1:0], apb.PWDATA[31:4]};

    assign w_fell     = r_core_d & ~MCU2IPU_CoreOnline;
    assign w_det[0]   = r_en & MCU2IPU_NMI & ~r_nmi_d;
    assign w_det[1]   = r_en & ~r_mask[1] & MCU2IPU_FaultInt & ~r_flt_d;
    assign w_det[2]   = r_en & ~r_mask[2] & MCU2IPU_IntValid;
    assign w_det[3]   = r_en & ~r_mask[3] & (|w_fell);
    assign w_new_info = {w_fell, MCU2IPU_IntInfo, 4'h0, 4'h0};

    always_comb begin
        w_gnt     = '0;
        w_gnt_src = '0;
        if (~w_full | w_pop) begin
            for (int i = 3; i >= 0; i--) begin
                if (r_pend[i]) begin
                    w_gnt     = 4'(1 << i);
                    w_gnt_src = 2'(i);
                end
            end
        end
    end

    assign w_push     = |w_gnt;
    assign w_push_evt = '{src: w_gnt_src, info: r_info[w_gnt_src], ts: r_ts};
    assign w_new_ovf  = |(w_det & r_pend & ~w_gnt);

    ipu_int_fifo #(.DEPTH(FIFO_DEPTH), .W(EVT_W)) u_fifo (
        .clk        (PCLK),
        .rst_n      (PRESETn),
        .i_push     (w_push),
        .i_push_dat (w_push_evt),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_cnt),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            IDX_CTRL:   w_rdata[0]   = r_en;
            IDX_MASK:   w_rdata[3:1] = r_mask;
            IDX_STATUS: begin
                w_rdata[2:0]  = 3'(w_cnt);
                w_rdata[3]    = w_full;
                w_rdata[4]    = w_empty;
                w_rdata[11:8] = r_pend;
                w_rdata[16]   = r_ovf;
            end
            IDX_EVENT:  if (!w_empty) w_rdata = {w_head.ts, 8'h00, w_head.info, 2'b00, w_head.src};
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_en     <= 1'b0;
            r_mask   <= '0;
            r_pend   <= '0;
            r_info   <= '0;
            r_ovf    <= 1'b0;
            r_ts     <= '0;
            r_nmi_d  <= 1'b0;
            r_flt_d  <= 1'b0;
            r_core_d <= 4'hF;
            r_prdata <= '0;
            r_pop_ok <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ts     <= r_ts + 16'd1;
            r_nmi_d  <= MCU2IPU_NMI;
            r_flt_d  <= MCU2IPU_FaultInt;
            r_core_d <= MCU2IPU_CoreOnline;
            r_irq    <= (w_cnt != '0) & r_en;
            for (int i = 0; i < 4; i++) begin
                if (w_det[i]) begin
                    r_pend[i] <= 1'b1;
                    r_info[i] <= w_new_info[i];
                end else if (w_gnt[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
            if (w_setup && !apb.PWRITE) begin
                r_prdata <= w_rdata;
                r_pop_ok <= (w_idx == IDX_EVENT) & ~w_empty;
            end else if (w_access) begin
                r_pop_ok <= 1'b0;
            end
            if (w_wr && w_idx == IDX_CTRL) r_en   <= apb.PWDATA[0];
            if (w_wr && w_idx == IDX_MASK) r_mask <= apb.PWDATA[3:1];
            // A fresh overflow wins over a simultaneous clear.
            if (w_new_ovf) r_ovf <= 1'b1;
            else if (w_wr && w_idx == IDX_OVFCLR && apb.PWDATA[0]) r_ovf <= 1'b0;
        end
    end

    assign apb.PRDATA = r_prdata;
    assign IPU_IRQ    = r_irq;
endmodule
